uart_hex_rx: RTL

UART receiver and hex-digit accumulator feeding the board's 8-digit multiplexed hex display. It samples the FPGAOL `rxd` line (8N1, LSB first) and emits each received byte. ASCII hex characters are decoded to nibbles and shifted into a 32-bit, 8-digit register. The display scanner consumes that register directly: digit 0 (bits [3:0]) is the newest character, shown at `an` = 0.

---
 rtl/uart_hex_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver feeding an 8-digit hex accumulator.
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   rxd         raw UART line, idle high, asynchronous to clk
//   clear       synchronous clear of digits, wins over a same-cycle shift
//   byte_out    last correctly framed byte, held between frames
//   byte_valid  one-cycle pulse when byte_out loads
//   frame_err   one-cycle pulse when the stop bit samples low
//   digits      eight hex nibbles, [3:0] is the newest character
//   digit_valid one-cycle pulse when digits shifts
module uart_hex_rx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic        clear,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        frame_err,
    output logic [31:0] digits,
    output logic        digit_valid
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          sync1, rx;
    logic          is_dec, is_alpha, is_hex;
    logic [7:0]    low;
    logic [3:0]    nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= rxd;
            rx    <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            byte_out   <= shreg;
                            byte_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_IDLE: if (rx) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Lower-casing via bit 5 lets one range test cover both letter cases.
    always_comb begin
        low      = byte_out | 8'h20;
        is_dec   = byte_out >= 8'h30 && byte_out <= 8'h39;
        is_alpha = low >= 8'h61 && low <= 8'h66;
        is_hex   = is_dec || is_alpha;
        nib      = is_dec ? byte_out[3:0] : byte_out[3:0] + 4'd9;
    end

    // byte_out already holds the new byte while byte_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= 1'b0;
        end else begin
            digit_valid <= byte_valid && is_hex && !clear;
            if (clear) digits <= '0;
            else if (byte_valid && is_hex) digits <= {digits[27:0], nib};
        end
    end
endmodule
